// File: rtl/display_scanner.sv
// VGA raster scanner: walks 640x480 timing, emits cell/pixel coords to the
// display ROMs and registers their colour onto the DAC pins with syncs.
module display_scanner #(
  parameter int GRID   = 10,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_rgb,
  output logic [5:0]  o_game_x,
  output logic [5:0]  o_game_y,
  output logic [3:0]  o_grid_x,
  output logic [3:0]  o_grid_y,
  output logic        o_visible,
  output logic        o_frame_start,
  output logic [7:0]  o_vga_r,
  output logic [7:0]  o_vga_g,
  output logic [7:0]  o_vga_b,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic        o_vga_blank_n,
  output logic        o_vga_sync_n
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VLST = HW'(H_VIS - 1);
  localparam logic [HW-1:0] H_VISW = HW'(H_VIS);
  localparam logic [HW-1:0] HS_ON  = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_OFF = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VLST = VW'(V_VIS - 1);
  localparam logic [VW-1:0] V_VISW = VW'(V_VIS);
  localparam logic [VW-1:0] VS_ON  = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_OFF = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [3:0]    G_LAST = 4'(GRID - 1);

  if (H_VIS / GRID > 64 || V_VIS / GRID > 64 || GRID > 16) begin : g_bad
    $error("display_scanner: cell grid exceeds coordinate widths");
  end

  logic          run_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [5:0]    gx_q, gx_d, gy_q, gy_d;
  logic [3:0]    cx_q, cx_d, cy_q, cy_d;
  logic          fs_q;
  logic [23:0]   rgb_q;
  logic          hs_q, vs_q, blank_q;
  logic          h_wrap, v_wrap, vis_pin;

  assign h_wrap    = (h_q == H_LAST);
  assign v_wrap    = (v_q == V_LAST);
  assign o_visible = (h_q < H_VISW) && (v_q < V_VISW);
  // The release edge only arms the scanner so (0,0) is presented for a full cycle.
  assign vis_pin   = o_visible && run_q;

  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    gx_d = gx_q;
    cx_d = cx_q;
    gy_d = gy_q;
    cy_d = cy_q;
    if (run_q) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap)
        v_d = v_wrap ? '0 : v_q + 1'b1;
      if (h_wrap || h_q == H_VLST) begin
        gx_d = '0;
        cx_d = '0;
      end else if (h_q < H_VISW) begin
        if (cx_q == G_LAST) begin
          cx_d = '0;
          gx_d = gx_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      if (h_wrap) begin
        if (v_wrap || v_q == V_VLST) begin
          gy_d = '0;
          cy_d = '0;
        end else if (v_q < V_VISW) begin
          if (cy_q == G_LAST) begin
            cy_d = '0;
            gy_d = gy_q + 1'b1;
          end else begin
            cy_d = cy_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q   <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      gx_q    <= '0;
      cx_q    <= '0;
      gy_q    <= '0;
      cy_q    <= '0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      h_q     <= h_d;
      v_q     <= v_d;
      gx_q    <= gx_d;
      cx_q    <= cx_d;
      gy_q    <= gy_d;
      cy_q    <= cy_d;
      fs_q    <= (h_d == '0) && (v_d == '0);
      rgb_q   <= vis_pin ? i_rgb : 24'h0;
      hs_q    <= !(h_q >= HS_ON && h_q < HS_OFF);
      vs_q    <= !(v_q >= VS_ON && v_q < VS_OFF);
      blank_q <= vis_pin;
    end
  end

  assign o_game_x      = gx_q;
  assign o_game_y      = gy_q;
  assign o_grid_x      = cx_q;
  assign o_grid_y      = cy_q;
  assign o_frame_start = fs_q;
  assign o_vga_r       = rgb_q[23:16];
  assign o_vga_g       = rgb_q[15:8];
  assign o_vga_b       = rgb_q[7:0];
  assign o_vga_hs      = hs_q;
  assign o_vga_vs      = vs_q;
  assign o_vga_blank_n = blank_q;
  assign o_vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_display_scanner.sv
// Bench: full-size and shrunken-timing scanners against an arithmetic
// raster model, random colour, mid-frame async reset.
module tb_display_scanner;

  int P [2][9] = '{
    '{10, 640, 16, 96, 48, 480, 10, 2, 33},
    '{4,  40,  4,  8,  4,  24,  2,  2, 3}
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rgb = '0;
  logic [23:0] prev_rgb = '0;

  logic [5:0] gx [2];
  logic [5:0] gy [2];
  logic [3:0] cx [2];
  logic [3:0] cy [2];
  logic       vis [2];
  logic       fs [2];
  logic [7:0] pr [2];
  logic [7:0] pg [2];
  logic [7:0] pb [2];
  logic       hs [2];
  logic       vs [2];
  logic       bn [2];
  logic       sn [2];

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int last_fs = 0;

  always #20 clk = ~clk;

  display_scanner u_full (
    .i_clk(clk), .i_rst_n(rst_n), .i_rgb(rgb),
    .o_game_x(gx[0]), .o_game_y(gy[0]),
    .o_grid_x(cx[0]), .o_grid_y(cy[0]),
    .o_visible(vis[0]), .o_frame_start(fs[0]),
    .o_vga_r(pr[0]), .o_vga_g(pg[0]), .o_vga_b(pb[0]),
    .o_vga_hs(hs[0]), .o_vga_vs(vs[0]),
    .o_vga_blank_n(bn[0]), .o_vga_sync_n(sn[0])
  );

  display_scanner #(
    .GRID(4), .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(24), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_rgb(rgb),
    .o_game_x(gx[1]), .o_game_y(gy[1]),
    .o_grid_x(cx[1]), .o_grid_y(cy[1]),
    .o_visible(vis[1]), .o_frame_start(fs[1]),
    .o_vga_r(pr[1]), .o_vga_g(pg[1]), .o_vga_b(pb[1]),
    .o_vga_hs(hs[1]), .o_vga_vs(vs[1]),
    .o_vga_blank_n(bn[1]), .o_vga_sync_n(sn[1])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int htot(input int i);
    return P[i][1] + P[i][2] + P[i][3] + P[i][4];
  endfunction

  function automatic int vtot(input int i);
    return P[i][5] + P[i][6] + P[i][7] + P[i][8];
  endfunction

  // {game_x, game_y, grid_x, grid_y, visible, frame_start}
  function automatic logic [21:0] mcoord(input int i, input int n);
    int h, v, g;
    logic [5:0] ex, ey;
    logic [3:0] ix, iy;
    g = P[i][0];
    h = n % htot(i);
    v = (n / htot(i)) % vtot(i);
    ex = (h < P[i][1]) ? 6'(h / g) : 6'd0;
    ix = (h < P[i][1]) ? 4'(h % g) : 4'd0;
    ey = (v < P[i][5]) ? 6'(v / g) : 6'd0;
    iy = (v < P[i][5]) ? 4'(v % g) : 4'd0;
    return {ex, ey, ix, iy,
            1'(h < P[i][1] && v < P[i][5]),
            1'(h == 0 && v == 0)};
  endfunction

  // {rgb, hs, vs, blank_n} seen on the pins in cycle n
  function automatic logic [26:0] mpins(input int i, input int n,
                                        input logic [23:0] c);
    int h, v, hs0, vs0;
    logic on;
    if (n == 0) return {24'h0, 1'b1, 1'b1, 1'b0};
    h = (n - 1) % htot(i);
    v = ((n - 1) / htot(i)) % vtot(i);
    hs0 = P[i][1] + P[i][2];
    vs0 = P[i][5] + P[i][6];
    on = (h < P[i][1]) && (v < P[i][5]);
    return {on ? c : 24'h0,
            1'(!(h >= hs0 && h < hs0 + P[i][3])),
            1'(!(v >= vs0 && v < vs0 + P[i][7])),
            on};
  endfunction

  task automatic check_cycle(input int n);
    logic [21:0] ec;
    logic [26:0] ep;
    string p;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "full." : "small.";
      ec = mcoord(i, n);
      ep = mpins(i, n, prev_rgb);
      check({p, "game_x"}, 32'(gx[i]), 32'(ec[21:16]));
      check({p, "game_y"}, 32'(gy[i]), 32'(ec[15:10]));
      check({p, "grid_x"}, 32'(cx[i]), 32'(ec[9:6]));
      check({p, "grid_y"}, 32'(cy[i]), 32'(ec[5:2]));
      check({p, "visible"}, 32'(vis[i]), 32'(ec[1]));
      check({p, "frame_start"}, 32'(fs[i]), 32'(ec[0]));
      check({p, "rgb"}, 32'({pr[i], pg[i], pb[i]}), 32'(ep[26:3]));
      check({p, "hs"}, 32'(hs[i]), 32'(ep[2]));
      check({p, "vs"}, 32'(vs[i]), 32'(ep[1]));
      check({p, "blank_n"}, 32'(bn[i]), 32'(ep[0]));
      check({p, "sync_n"}, 32'(sn[i]), 32'd0);
    end
  endtask

  task automatic check_reset(input string when);
    for (int i = 0; i < 2; i++) begin
      check({when, ".coords"},
            32'({gx[i], gy[i], cx[i], cy[i]}), 32'd0);
      check({when, ".frame_start"}, 32'(fs[i]), 32'd0);
      check({when, ".rgb"}, 32'({pr[i], pg[i], pb[i]}), 32'd0);
      check({when, ".hs_vs"}, 32'({hs[i], vs[i]}), 32'd3);
      check({when, ".blank_n"}, 32'(bn[i]), 32'd0);
    end
  endtask

  task automatic run(input int count);
    int sm_frame;
    sm_frame = htot(1) * vtot(1);
    for (int k = 0; k < count; k++) begin
      @(negedge clk);
      check_cycle(cyc);
      if (fs[1] && cyc > 0) begin
        check("small.fs_period", 32'(cyc - last_fs), 32'(sm_frame));
        last_fs = cyc;
      end
      prev_rgb = ($urandom_range(3) == 0) ? 24'hFF8000 : 24'($urandom);
      rgb = prev_rgb;
      cyc++;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc = 0;
    last_fs = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    release_reset();
    // full timing reaches h=300 at cycle 9100 (line 11)
    run(9101);
    #5 rst_n = 1'b0;
    #1 check_reset("async_reset");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset("held_reset");
    end
    release_reset();
    run(4000);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
